// File: rtl/leg_gate_controller.sv
// Half-bridge leg sequencer: turns a PWM command into complementary gate requests and applies
// dead-time updates only at instants where no dead band is being counted.
module leg_gate_controller #(
  parameter int DT_W       = 5,
  parameter int DT_DEFAULT = 10,
  parameter int DT_MIN     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_pwm,
  input  logic            i_fault,
  input  logic            i_fault_clr,
  input  logic            i_dt_wr,
  input  logic [DT_W-1:0] i_dt_wdata,
  output logic            o_gi_hi,
  output logic            o_gi_lo,
  output logic [DT_W-1:0] o_dt,
  output logic            o_dt_pending,
  output logic            o_dt_err,
  output logic            o_fault_latched,
  output logic [1:0]      o_state
);

  // state | meaning
  // IDLE  | gates off, waiting for en with no fault
  // RUN   | gates follow pwm_q, dt commits only on pwm_q edges
  // FAULT | gates forced off until fault_clr with fault released
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pwm_q;
  logic            r_pwm_qq;
  logic            r_gi_hi;
  logic            r_gi_lo;
  logic            r_fault_latched;
  logic [DT_W-1:0] r_dt;
  logic [DT_W-1:0] r_shadow;
  logic            r_dt_pending;
  logic            r_dt_err;
  logic            w_gi_hi_nxt;
  logic            w_gi_lo_nxt;
  logic            w_wr_ok;
  logic            w_pwm_edge;
  logic            w_commit;

  assign w_wr_ok    = i_dt_wr && (i_dt_wdata >= DT_W'(DT_MIN));
  // pwm_q changed on the previous edge, so gi changes on the coming one: dt must move with it
  assign w_pwm_edge = r_pwm_q ^ r_pwm_qq;
  assign w_commit   = (r_state != ST_RUN) || w_pwm_edge;

  always_comb begin
    w_state_nxt = r_state;
    w_gi_hi_nxt = 1'b0;
    w_gi_lo_nxt = 1'b0;
    if (i_fault) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_en)        w_state_nxt = ST_RUN;
        ST_RUN:   if (!i_en)       w_state_nxt = ST_IDLE;
        ST_FAULT: if (i_fault_clr) w_state_nxt = ST_IDLE;
        default:                   w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_state_nxt == ST_RUN) begin
      w_gi_hi_nxt = r_pwm_q;
      w_gi_lo_nxt = ~r_pwm_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_pwm_q         <= 1'b0;
      r_pwm_qq        <= 1'b0;
      r_gi_hi         <= 1'b0;
      r_gi_lo         <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_pwm_q         <= i_pwm;
      r_pwm_qq        <= r_pwm_q;
      r_gi_hi         <= w_gi_hi_nxt;
      r_gi_lo         <= w_gi_lo_nxt;
      r_fault_latched <= (w_state_nxt == ST_FAULT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dt         <= DT_W'(DT_DEFAULT);
      r_shadow     <= DT_W'(DT_DEFAULT);
      r_dt_pending <= 1'b0;
      r_dt_err     <= 1'b0;
    end else begin
      if (i_dt_wr) r_dt_err <= ~w_wr_ok;
      if (w_wr_ok) r_shadow <= i_dt_wdata;
      if (w_commit) begin
        r_dt_pending <= 1'b0;
        if (w_wr_ok)           r_dt <= i_dt_wdata;
        else if (r_dt_pending) r_dt <= r_shadow;
      end else if (w_wr_ok) begin
        r_dt_pending <= 1'b1;
      end
    end
  end

  assign o_gi_hi         = r_gi_hi;
  assign o_gi_lo         = r_gi_lo;
  assign o_dt            = r_dt;
  assign o_dt_pending    = r_dt_pending;
  assign o_dt_err        = r_dt_err;
  assign o_fault_latched = r_fault_latched;
  assign o_state         = r_state;

endmodule

// File: tb/tb_leg_gate_controller.sv
// Bench for leg_gate_controller: directed scenarios then random traffic, every cycle compared
// against a behavioural model of the leg.
module tb_leg_gate_controller;

  localparam int DT_W       = 5;
  localparam int DT_DEFAULT = 10;
  localparam int DT_MIN     = 2;

  logic            clk = 1'b0;
  logic            rst, en, pwm, fault, fault_clr, dt_wr;
  logic [DT_W-1:0] dt_wdata;
  logic            gi_hi, gi_lo, dt_pending, dt_err, fault_latched;
  logic [DT_W-1:0] dt;
  logic [1:0]      state;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 fault
  int m_state, m_pq, m_pq_prev, m_gh, m_gl, m_dt, m_sh, m_pend, m_err;

  leg_gate_controller #(.DT_W(DT_W), .DT_DEFAULT(DT_DEFAULT), .DT_MIN(DT_MIN)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_pwm(pwm), .i_fault(fault),
    .i_fault_clr(fault_clr), .i_dt_wr(dt_wr), .i_dt_wdata(dt_wdata),
    .o_gi_hi(gi_hi), .o_gi_lo(gi_lo), .o_dt(dt), .o_dt_pending(dt_pending),
    .o_dt_err(dt_err), .o_fault_latched(fault_latched), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_next();
    int ns, safe, ok;
    if (rst) begin
      m_state = 0; m_pq = 0; m_pq_prev = 0; m_gh = 0; m_gl = 0;
      m_dt = DT_DEFAULT; m_sh = DT_DEFAULT; m_pend = 0; m_err = 0;
      return;
    end
    if (fault)                           ns = 2;
    else if (m_state == 0)               ns = en ? 1 : 0;
    else if (m_state == 1)               ns = en ? 1 : 0;
    else                                 ns = fault_clr ? 0 : 2;
    safe = (m_state != 1) || (m_pq != m_pq_prev);
    ok   = dt_wr && (int'(dt_wdata) >= DT_MIN);
    if (dt_wr) m_err = ok ? 0 : 1;
    if (safe) begin
      if (ok)          m_dt = int'(dt_wdata);
      else if (m_pend) m_dt = m_sh;
      m_pend = 0;
    end else if (ok) begin
      m_pend = 1;
    end
    if (ok) m_sh = int'(dt_wdata);
    m_gh = (ns == 1) ? m_pq : 0;
    m_gl = (ns == 1) ? 1 - m_pq : 0;
    m_pq_prev = m_pq;
    m_pq = pwm;
    m_state = ns;
  endtask

  task automatic cyc();
    model_next();
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("gi_hi", gi_hi, m_gh);
    chk("gi_lo", gi_lo, m_gl);
    chk("gi_excl", gi_hi & gi_lo, 0);
    chk("dt", dt, m_dt);
    chk("dt_pending", dt_pending, m_pend);
    chk("dt_err", dt_err, m_err);
    chk("fault_latched", fault_latched, m_state == 2);
  endtask

  task automatic idle_inputs();
    fault = 0; fault_clr = 0; dt_wr = 0; dt_wdata = '0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(input int v);
    dt_wr = 1; dt_wdata = DT_W'(v);
    cyc();
    dt_wr = 0;
  endtask

  initial begin
    rst = 1; en = 0; pwm = 0; idle_inputs();
    cyc();
    chk("rst_dt", dt, DT_DEFAULT);
    chk("rst_state", state, 0);
    rst = 0;

    // 1: pwm every 20 cycles, gates trail by two
    en = 1;
    for (int p = 0; p < 4; p++) begin
      pwm = p[0];
      run_cycles(20);
    end

    // 2: write 4 mid-period, commit on the next pwm_q edge
    pwm = 1; run_cycles(5);
    write(4);
    chk("t2_pend", dt_pending, 1);
    chk("t2_dt_hold", dt, DT_DEFAULT);
    run_cycles(5);
    pwm = 0; cyc(); cyc();
    chk("t2_dt_commit", dt, 4);
    chk("t2_pend_clr", dt_pending, 0);

    // 3: reject below DT_MIN, then accept 6
    run_cycles(3);
    write(1);
    chk("t3_err", dt_err, 1);
    chk("t3_dt", dt, 4);
    write(6);
    chk("t3_err_clr", dt_err, 0);
    chk("t3_pend", dt_pending, 1);
    run_cycles(3);

    // 4: fault handling
    fault = 1; cyc();
    chk("t4_state", state, 2);
    fault_clr = 1; cyc();
    chk("t4_clr_ignored", state, 2);
    fault = 0; fault_clr = 0; en = 0; cyc(); en = 1; cyc();
    chk("t4_en_ignored", state, 2);
    fault_clr = 1; cyc(); fault_clr = 0;
    chk("t4_idle", state, 0);
    cyc();
    chk("t4_run", state, 1);
    run_cycles(4);

    // 5: write coincident with pwm_q edge, then while idle
    pwm = ~pwm; cyc();
    write(8);
    chk("t5_dt", dt, 8);
    chk("t5_pend", dt_pending, 0);
    en = 0; cyc();
    write(7);
    chk("t5_idle_dt", dt, 7);
    chk("t5_idle_pend", dt_pending, 0);

    // 6: reset mid-run with a pending write
    en = 1; run_cycles(3);
    write(12);
    chk("t6_pre_pend", dt_pending, 1);
    rst = 1; cyc(); rst = 0;
    chk("t6_dt", dt, DT_DEFAULT);
    chk("t6_pend", dt_pending, 0);
    chk("t6_gi", {gi_hi, gi_lo}, 0);
    chk("t6_state", state, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  pwm = ~pwm;
      en        = ($urandom_range(19) != 0);
      if ($urandom_range(149) == 0) fault = 1;
      else if ($urandom_range(3) == 0) fault = 0;
      fault_clr = ($urandom_range(9) == 0);
      dt_wr     = ($urandom_range(5) == 0);
      dt_wdata  = DT_W'($urandom_range(3) == 0 ? $urandom_range(3) : $urandom_range(31));
      rst       = ($urandom_range(299) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
